// File: rtl/usr_extract.sv
`default_nettype none
// ============================================================================
//  Module      : usr_extract
//  Description : Receive-side user-data extractor. Checks the EtherType,
//                strips the 14-byte MAC header and re-aligns the payload to
//                byte 0 of a 512-bit user stream; other frames are dropped.
//  Revision    : 1.0
// ============================================================================
module usr_extract #(
  parameter logic [15:0] USR_ETHTYPE = 16'h88B5,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [511:0]     in_data,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [5:0]       in_empty,
  output logic             in_ready,
  output logic [511:0]     out_usr_data,
  output logic             out_usr_valid,
  output logic             out_usr_sop,
  output logic             out_usr_eop,
  output logic [5:0]       out_usr_empty,
  input  logic             out_usr_ready,
  output logic [CNT_W-1:0] usr_pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  // 14 header bytes leave 50 payload bytes in the sop flit
  localparam logic [5:0] c_RUNT_EMPTY = 6'd50;
  localparam logic [5:0] c_HDR_BYTES  = 6'd14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BODY = 2'd1,
    S_TAIL = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [399:0]       r_carry;
  logic               r_first;
  logic [5:0]         r_tail_empty;
  logic [511:0]       r_out_data;
  logic               r_out_valid;
  logic               r_out_sop;
  logic               r_out_eop;
  logic [5:0]         r_out_empty;
  logic [CNT_W-1:0]   r_usr_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;

  logic               w_advance;
  logic               w_accept;
  logic               w_short_eop;
  logic               w_emit;
  logic [511:0]       w_data;
  logic               w_sop;
  logic               w_eop;
  logic [5:0]         w_empty;
  logic               w_carry_ld;
  logic               w_first_set;
  logic               w_first_clr;
  logic               w_tail_ld;
  logic               w_usr_inc;
  logic               w_drop_inc;

  assign w_advance   = !r_out_valid || out_usr_ready;
  assign in_ready    = (r_state == S_DROP) ? 1'b1 :
                       (r_state == S_TAIL) ? 1'b0 : w_advance;
  assign w_accept    = in_valid && in_ready;
  // eop flit holding at most 14 valid bytes (V = 64 - in_empty <= 14)
  assign w_short_eop = (in_empty >= c_RUNT_EMPTY);

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_data      = {r_carry, 112'b0};
    w_sop       = 1'b0;
    w_eop       = 1'b0;
    w_empty     = 6'd0;
    w_carry_ld  = 1'b0;
    w_first_set = 1'b0;
    w_first_clr = 1'b0;
    w_tail_ld   = 1'b0;
    w_usr_inc   = 1'b0;
    w_drop_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && in_sop) begin
          if (in_data[415:400] != USR_ETHTYPE) begin
            w_drop_inc = 1'b1;
            if (!in_eop) w_state_nxt = S_DROP;
          end else if (in_eop) begin
            if (w_short_eop) begin
              w_drop_inc = 1'b1;
            end else begin
              w_emit    = 1'b1;
              w_data    = {in_data[399:0], 112'b0};
              w_sop     = 1'b1;
              w_eop     = 1'b1;
              w_empty   = in_empty + c_HDR_BYTES;
              w_usr_inc = 1'b1;
            end
          end else begin
            w_carry_ld  = 1'b1;
            w_first_set = 1'b1;
            w_state_nxt = S_BODY;
          end
        end
      end
      S_BODY: begin
        if (w_accept) begin
          w_emit      = 1'b1;
          w_data      = {r_carry, in_data[511:400]};
          w_sop       = r_first;
          w_first_clr = 1'b1;
          w_carry_ld  = 1'b1;
          if (in_eop) begin
            if (w_short_eop) begin
              w_eop       = 1'b1;
              w_empty     = in_empty - c_RUNT_EMPTY;
              w_usr_inc   = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_tail_ld   = 1'b1;
              w_state_nxt = S_TAIL;
            end
          end
        end
      end
      S_TAIL: begin
        if (w_advance) begin
          w_emit      = 1'b1;
          w_data      = {r_carry, 112'b0};
          w_eop       = 1'b1;
          w_empty     = r_tail_empty;
          w_usr_inc   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (w_accept && in_eop) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_carry      <= '0;
      r_first      <= 1'b0;
      r_tail_empty <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_sop    <= 1'b0;
      r_out_eop    <= 1'b0;
      r_out_empty  <= '0;
      r_usr_cnt    <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_carry_ld)  r_carry      <= in_data[399:0];
      if (w_first_set) r_first      <= 1'b1;
      else if (w_first_clr) r_first <= 1'b0;
      if (w_tail_ld)   r_tail_empty <= in_empty + c_HDR_BYTES;
      if (w_advance) begin
        r_out_valid <= w_emit;
        r_out_sop   <= w_sop;
        r_out_eop   <= w_eop;
        if (w_emit) begin
          r_out_data  <= w_data;
          r_out_empty <= w_empty;
        end
      end
      if (w_usr_inc)  r_usr_cnt  <= r_usr_cnt + 1'b1;
      if (w_drop_inc) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign out_usr_data  = r_out_data;
  assign out_usr_valid = r_out_valid;
  assign out_usr_sop   = r_out_sop;
  assign out_usr_eop   = r_out_eop;
  assign out_usr_empty = r_out_empty;
  assign usr_pkt_cnt   = r_usr_cnt;
  assign drop_cnt      = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_usr_extract.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usr_extract
//  Description : Scoreboard bench for usr_extract; frames are built byte-wise
//                and the expected user flits are derived from the raw payload.
//  Revision    : 1.0
// ============================================================================
module tb_usr_extract;

  localparam logic [15:0] c_ETH_USR = 16'h88B5;

  typedef struct packed {
    logic [511:0] d;
    logic         s;
    logic         e;
    logic [5:0]   m;
  } flit_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_sop = 1'b0;
  logic         in_eop = 1'b0;
  logic [5:0]   in_empty = '0;
  logic         in_ready;
  logic [511:0] out_usr_data;
  logic         out_usr_valid;
  logic         out_usr_sop;
  logic         out_usr_eop;
  logic [5:0]   out_usr_empty;
  logic         out_usr_ready = 1'b1;
  logic [31:0]  usr_pkt_cnt;
  logic [31:0]  drop_cnt;

  flit_t sb[$];
  int    total = 0;
  int    bad = 0;
  int    exp_usr = 0;
  int    exp_drop = 0;
  int    ready_mode = 0;
  bit    saw_nr = 1'b0;
  bit    have_hold = 1'b0;
  flit_t hold;

  usr_extract #(.USR_ETHTYPE(c_ETH_USR), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_ready(in_ready),
    .out_usr_data(out_usr_data), .out_usr_valid(out_usr_valid),
    .out_usr_sop(out_usr_sop), .out_usr_eop(out_usr_eop),
    .out_usr_empty(out_usr_empty), .out_usr_ready(out_usr_ready),
    .usr_pkt_cnt(usr_pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       out_usr_ready = 1'($urandom_range(0, 1));
      2:       out_usr_ready = 1'b0;
      default: out_usr_ready = 1'b1;
    endcase
  end

  function automatic void check(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endfunction

  function automatic logic [7:0] pbyte(input int seed, input int idx);
    return 8'((seed * 37 + idx * 11 + 5) & 255);
  endfunction

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    flit_t cur;
    flit_t exp;
    cur = '{d: out_usr_data, s: out_usr_sop, e: out_usr_eop, m: out_usr_empty};
    if (rst) begin
      have_hold = 1'b0;
    end else begin
      if (have_hold) check("stable_while_stalled", 512'(cur), 512'(hold));
      have_hold = out_usr_valid && !out_usr_ready;
      hold      = cur;
      if (!out_usr_valid) check("sop_eop_idle", {out_usr_sop, out_usr_eop}, 2'b00);
      if (out_usr_valid && out_usr_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got data %0h want none", out_usr_data);
        end else begin
          exp = sb.pop_front();
          check("out_data", cur.d, exp.d);
          check("out_sop_eop_empty", {cur.s, cur.e, cur.m}, {exp.s, exp.e, exp.m});
        end
      end
    end
  end

  task automatic send_flit(input logic [511:0] d, input logic s, input logic e, input logic [5:0] m);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    in_data = d; in_sop = s; in_eop = e; in_empty = m; in_valid = 1'b1;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = in_ready;
      if (!in_ready) saw_nr = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0 want 1");
    end
  endtask

  // partial=1 sends only the first two flits and records no expectation
  task automatic send_frame(input logic [15:0] et, input int plen, input int seed, input bit partial);
    logic [7:0]   fb[$];
    logic [511:0] d;
    flit_t        f;
    int           flen, nfl, nout, idx;
    for (int i = 0; i < 6; i++) fb.push_back(8'(8'hA0 + i));
    for (int i = 0; i < 6; i++) fb.push_back(8'(8'hB0 + i));
    fb.push_back(et[15:8]);
    fb.push_back(et[7:0]);
    for (int i = 0; i < plen; i++) fb.push_back(pbyte(seed, i));
    if (!partial) begin
      if (et == c_ETH_USR && plen > 0) begin
        nout = (plen + 63) / 64;
        for (int k = 0; k < nout; k++) begin
          d = '0;
          for (int j = 0; j < 64; j++) begin
            idx = k * 64 + j;
            if (idx < plen) d[511 - 8*j -: 8] = pbyte(seed, idx);
          end
          f.d = d;
          f.s = (k == 0);
          f.e = (k == nout - 1);
          f.m = (k == nout - 1) ? 6'(nout * 64 - plen) : 6'd0;
          sb.push_back(f);
        end
        exp_usr++;
      end else begin
        exp_drop++;
      end
    end
    flen = fb.size();
    nfl  = (flen + 63) / 64;
    if (partial && nfl > 2) nfl = 2;
    for (int k = 0; k < nfl; k++) begin
      d = '0;
      for (int j = 0; j < 64; j++) begin
        idx = k * 64 + j;
        if (idx < flen) d[511 - 8*j -: 8] = fb[idx];
      end
      send_flit(d, k == 0, !partial && (k == nfl - 1),
                (!partial && k == nfl - 1) ? 6'(nfl * 64 - flen) : 6'd0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 512'(sb.size()), 512'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", {out_usr_valid, out_usr_sop, out_usr_eop}, 3'b000);
    check("reset_usr_cnt", usr_pkt_cnt, 0);
    check("reset_drop_cnt", drop_cnt, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    send_frame(c_ETH_USR, 192, 1, 1'b0);
    drain();
    check("loopback_usr_cnt", usr_pkt_cnt, 32'(exp_usr));

    send_frame(c_ETH_USR, 60, 2, 1'b0);
    drain();

    send_frame(c_ETH_USR, 94, 3, 1'b0);
    @(negedge clk);
    check("tail_in_ready_low", in_ready, 0);
    @(negedge clk);
    check("tail_in_ready_back", in_ready, 1);
    drain();

    send_frame(c_ETH_USR, 20, 4, 1'b0);
    drain();
    check("short_usr_cnt", usr_pkt_cnt, 32'(exp_usr));

    saw_nr = 1'b0;
    send_frame(16'h0800, 300, 5, 1'b0);
    check("drop_in_ready_held", saw_nr, 0);
    drain();
    check("drop_cnt_ethtype", drop_cnt, 32'(exp_drop));

    send_frame(c_ETH_USR, 0, 6, 1'b0);
    drain();
    check("drop_cnt_runt", drop_cnt, 32'(exp_drop));

    ready_mode = 1;
    for (int i = 0; i < 20; i++) send_frame(c_ETH_USR, int'($urandom_range(1, 200)), 10 + i, 1'b0);
    drain();
    ready_mode = 0;
    drain();
    check("random_usr_cnt", usr_pkt_cnt, 32'(exp_usr));
    check("random_drop_cnt", drop_cnt, 32'(exp_drop));

    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_frame(c_ETH_USR, 200, 7, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    exp_usr  = 0;
    exp_drop = 0;
    @(negedge clk);
    check("midreset_valid", out_usr_valid, 0);
    check("midreset_cnts", {usr_pkt_cnt, drop_cnt}, 64'd0);
    ready_mode = 0;
    @(posedge clk);
    #1;
    send_frame(c_ETH_USR, 80, 8, 1'b0);
    drain();
    check("post_reset_usr_cnt", usr_pkt_cnt, 32'(exp_usr));
    check("post_reset_drop_cnt", drop_cnt, 32'(exp_drop));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
